// File: rtl/noc_flit_packetizer_if.sv
// rtl/noc_flit_packetizer_if.sv - descriptor, payload and FIFO-side signals of the flit packetizer
interface noc_flit_packetizer_if #(
  parameter int bit_width  = 16,
  parameter int dest_width = 4,
  parameter int len_width  = 3
);
  logic                  pkt_valid;
  logic                  pkt_ready;
  logic [dest_width-1:0] pkt_dest;
  logic [len_width-1:0]  pkt_len;
  logic                  word_valid;
  logic                  word_ready;
  logic [bit_width-3:0]  word_data;
  logic                  buf_full;
  logic                  buf_load;
  logic [bit_width-1:0]  buf_data;
  logic [7:0]            pkt_sent;

  // Environment view: PE descriptor/payload source and FIFO full flag
  modport master (
    output pkt_valid, pkt_dest, pkt_len, word_valid, word_data, buf_full,
    input  pkt_ready, word_ready, buf_load, buf_data, pkt_sent
  );

  // Packetizer view
  modport slave (
    input  pkt_valid, pkt_dest, pkt_len, word_valid, word_data, buf_full,
    output pkt_ready, word_ready, buf_load, buf_data, pkt_sent
  );
endinterface

// File: rtl/noc_flit_packetizer.sv
// rtl/noc_flit_packetizer.sv - head/payload flit injector for the NoC write-side FIFO (optional NOC_PKT_CHECKSUM_EN)
module noc_flit_packetizer #(
  parameter int bit_width  = 16,
  parameter int dest_width = 4,
  parameter int len_width  = 3
) (
  input logic                    clk_w,
  input logic                    rst,
  noc_flit_packetizer_if.slave   bus
);

  localparam logic [1:0] T_HEAD   = 2'b10;
  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_TAIL   = 2'b01;
  localparam logic [1:0] T_SINGLE = 2'b11;

  if (2 + dest_width + len_width > bit_width) begin : g_bad_cfg
    $error("noc_flit_packetizer: header fields do not fit in bit_width");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_BODY = 2'd2
`ifdef NOC_PKT_CHECKSUM_EN
    , S_CRC = 2'd3
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [dest_width-1:0] dest_q;
  logic [len_width-1:0]  len_q;
  logic [len_width-1:0]  rem_q;
  logic [7:0]            pkt_sent_q;
`ifdef NOC_PKT_CHECKSUM_EN
  logic [bit_width-3:0]  csum_q;
`endif

  logic                  accept;
  logic                  word_fire;
  logic                  pkt_done;
  logic                  last_word;

  assign accept    = (state_q == S_IDLE) && bus.pkt_valid;
  assign word_fire = (state_q == S_BODY) && bus.word_valid && !bus.buf_full;
  assign last_word = (rem_q == len_width'(1));

`ifdef NOC_PKT_CHECKSUM_EN
  assign pkt_done = (state_q == S_CRC) && !bus.buf_full;
`else
  assign pkt_done = ((state_q == S_HEAD) && !bus.buf_full && (len_q == '0)) ||
                    (word_fire && last_word);
`endif

  // State register
  always_ff @(posedge clk_w) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: advance only on a real FIFO load, so a full FIFO freezes the flit
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.pkt_valid) state_d = S_HEAD;
      S_HEAD: begin
        if (!bus.buf_full) begin
`ifdef NOC_PKT_CHECKSUM_EN
          state_d = (len_q == '0) ? S_CRC : S_BODY;
`else
          state_d = (len_q == '0) ? S_IDLE : S_BODY;
`endif
        end
      end
      S_BODY: begin
        if (word_fire && last_word) begin
`ifdef NOC_PKT_CHECKSUM_EN
          state_d = S_CRC;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef NOC_PKT_CHECKSUM_EN
      S_CRC: if (!bus.buf_full) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: handshakes and flit image decoded from state, word_valid and buf_full
  always_comb begin
    bus.pkt_ready  = 1'b0;
    bus.word_ready = 1'b0;
    bus.buf_load   = 1'b0;
    bus.buf_data   = '0;
    case (state_q)
      S_IDLE: bus.pkt_ready = 1'b1;
      S_HEAD: begin
        bus.buf_load = !bus.buf_full;
`ifdef NOC_PKT_CHECKSUM_EN
        bus.buf_data[bit_width-1 -: 2] = T_HEAD;
`else
        bus.buf_data[bit_width-1 -: 2] = (len_q == '0) ? T_SINGLE : T_HEAD;
`endif
        bus.buf_data[bit_width-3 -: dest_width]            = dest_q;
        bus.buf_data[bit_width-3-dest_width -: len_width]  = len_q;
      end
      S_BODY: begin
        bus.word_ready = !bus.buf_full;
        bus.buf_load   = bus.word_valid && !bus.buf_full;
`ifdef NOC_PKT_CHECKSUM_EN
        bus.buf_data   = {T_BODY, bus.word_data};
`else
        bus.buf_data   = {(last_word ? T_TAIL : T_BODY), bus.word_data};
`endif
      end
`ifdef NOC_PKT_CHECKSUM_EN
      S_CRC: begin
        bus.buf_load = !bus.buf_full;
        bus.buf_data = {T_TAIL, csum_q};
      end
`endif
      default: ;
    endcase
  end

  // Descriptor latch, remaining-word counter, checksum and packet counter
  always_ff @(posedge clk_w) begin
    if (rst) begin
      dest_q     <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      pkt_sent_q <= '0;
`ifdef NOC_PKT_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      if (accept) begin
        dest_q <= bus.pkt_dest;
        len_q  <= bus.pkt_len;
        rem_q  <= bus.pkt_len;
`ifdef NOC_PKT_CHECKSUM_EN
        csum_q <= '0;
`endif
      end
      if (word_fire) begin
        rem_q  <= rem_q - len_width'(1);
`ifdef NOC_PKT_CHECKSUM_EN
        csum_q <= csum_q ^ bus.word_data;
`endif
      end
      if (pkt_done) pkt_sent_q <= pkt_sent_q + 8'd1;
    end
  end

  assign bus.pkt_sent = pkt_sent_q;

endmodule

// File: tb/tb_noc_flit_packetizer.sv
// tb/tb_noc_flit_packetizer.sv - directed vector bench for noc_flit_packetizer
module tb_noc_flit_packetizer;

  logic clk_w = 1'b0;
  logic rst   = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_w = ~clk_w;

  noc_flit_packetizer_if #(.bit_width(16), .dest_width(4), .len_width(3)) bus_if ();

  noc_flit_packetizer #(.bit_width(16), .dest_width(4), .len_width(3)) dut (
    .clk_w (clk_w),
    .rst   (rst),
    .bus   (bus_if.slave)
  );

  typedef struct {
    logic        pv;
    logic [3:0]  pd;
    logic [2:0]  pl;
    logic        wv;
    logic [13:0] wd;
    logic        bf;
    logic        e_pr;
    logic        e_wr;
    logic        e_ld;
    logic [15:0] e_data;
    logic [7:0]  e_sent;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic pv, logic [3:0] pd, logic [2:0] pl, logic wv,
                              logic [13:0] wd, logic bf, logic pr, logic wr, logic ld,
                              logic [15:0] dt, logic [7:0] st);
    vec_t v;
    v.pv = pv; v.pd = pd; v.pl = pl; v.wv = wv; v.wd = wd; v.bf = bf;
    v.e_pr = pr; v.e_wr = wr; v.e_ld = ld; v.e_data = dt; v.e_sent = st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [3:0] pd, input logic [2:0] pl,
                       input logic wv, input logic [13:0] wd, input logic bf);
    bus_if.pkt_valid  = pv;
    bus_if.pkt_dest   = pd;
    bus_if.pkt_len    = pl;
    bus_if.word_valid = wv;
    bus_if.word_data  = wd;
    bus_if.buf_full   = bf;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk_w);
    drive(v.pv, v.pd, v.pl, v.wv, v.wd, v.bf);
    #1;
    chk($sformatf("row%0d.pkt_ready", idx),  32'(bus_if.pkt_ready),  32'(v.e_pr));
    chk($sformatf("row%0d.word_ready", idx), 32'(bus_if.word_ready), 32'(v.e_wr));
    chk($sformatf("row%0d.buf_load", idx),   32'(bus_if.buf_load),   32'(v.e_ld));
    chk($sformatf("row%0d.buf_data", idx),   32'(bus_if.buf_data),   32'(v.e_data));
    chk($sformatf("row%0d.pkt_sent", idx),   32'(bus_if.pkt_sent),   32'(v.e_sent));
  endtask

  // Head layout: [15:14] type, [13:10] dest, [9:7] len, [6:0] zero
  initial begin
`ifdef NOC_PKT_CHECKSUM_EN
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b0,14'h0,1'b0, 1'b1,1'b0,1'b0,16'h0000,8'd0));
    tbl.push_back(mk(1'b1,4'd5,3'd0,1'b0,14'h0,1'b0, 1'b1,1'b0,1'b0,16'h0000,8'd0));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b0,14'h0,1'b0, 1'b0,1'b0,1'b1,16'h9400,8'd0));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b0,14'h0,1'b0, 1'b0,1'b0,1'b1,16'h4000,8'd0));
    tbl.push_back(mk(1'b1,4'd3,3'd2,1'b0,14'h0,1'b0, 1'b1,1'b0,1'b0,16'h0000,8'd1));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b1,14'h1,1'b0, 1'b0,1'b0,1'b1,16'h8D00,8'd1));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b1,14'h1,1'b0, 1'b0,1'b1,1'b1,16'h0001,8'd1));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b1,14'h2,1'b0, 1'b0,1'b1,1'b1,16'h0002,8'd1));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b0,14'h0,1'b1, 1'b0,1'b0,1'b0,16'h4003,8'd1));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b0,14'h0,1'b0, 1'b0,1'b0,1'b1,16'h4003,8'd1));
    tbl.push_back(mk(1'b1,4'd10,3'd3,1'b0,14'h0,1'b0, 1'b1,1'b0,1'b0,16'h0000,8'd2));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b0,14'h0,1'b0, 1'b0,1'b0,1'b1,16'hA980,8'd2));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b1,14'h1111,1'b0, 1'b0,1'b1,1'b1,16'h1111,8'd2));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b0,14'h2222,1'b0, 1'b0,1'b1,1'b0,16'h2222,8'd2));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b1,14'h2222,1'b0, 1'b0,1'b1,1'b1,16'h2222,8'd2));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b1,14'h3fff,1'b0, 1'b0,1'b1,1'b1,16'h3fff,8'd2));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b0,14'h0,1'b0, 1'b0,1'b0,1'b1,16'h4CCC,8'd2));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b0,14'h0,1'b0, 1'b1,1'b0,1'b0,16'h0000,8'd3));
`else
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b0,14'h0,1'b0, 1'b1,1'b0,1'b0,16'h0000,8'd0));
    // single-flit packet
    tbl.push_back(mk(1'b1,4'd5,3'd0,1'b0,14'h0,1'b0, 1'b1,1'b0,1'b0,16'h0000,8'd0));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b0,14'h0,1'b0, 1'b0,1'b0,1'b1,16'hD400,8'd0));
    // len 2, no stalls; word_valid high in HEAD must not be taken
    tbl.push_back(mk(1'b1,4'd3,3'd2,1'b0,14'h0,1'b0, 1'b1,1'b0,1'b0,16'h0000,8'd1));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b1,14'h1,1'b0, 1'b0,1'b0,1'b1,16'h8D00,8'd1));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b1,14'h1,1'b0, 1'b0,1'b1,1'b1,16'h0001,8'd1));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b1,14'h2,1'b0, 1'b0,1'b1,1'b1,16'h4002,8'd1));
    // same packet, full in HEAD once and for 3 cycles on the first payload flit
    tbl.push_back(mk(1'b1,4'd3,3'd2,1'b0,14'h0,1'b0, 1'b1,1'b0,1'b0,16'h0000,8'd2));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b0,14'h0,1'b1, 1'b0,1'b0,1'b0,16'h8D00,8'd2));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b0,14'h0,1'b0, 1'b0,1'b0,1'b1,16'h8D00,8'd2));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1'b0,4'd0,3'd0,1'b1,14'h1,1'b1, 1'b0,1'b0,1'b0,16'h0001,8'd2));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b1,14'h1,1'b0, 1'b0,1'b1,1'b1,16'h0001,8'd2));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b1,14'h2,1'b0, 1'b0,1'b1,1'b1,16'h4002,8'd2));
    // len 3 with a two-cycle word_valid gap
    tbl.push_back(mk(1'b1,4'd10,3'd3,1'b0,14'h0,1'b0, 1'b1,1'b0,1'b0,16'h0000,8'd3));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b0,14'h0,1'b0, 1'b0,1'b0,1'b1,16'hA980,8'd3));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b1,14'h1111,1'b0, 1'b0,1'b1,1'b1,16'h1111,8'd3));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b0,14'h2222,1'b0, 1'b0,1'b1,1'b0,16'h2222,8'd3));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b0,14'h2222,1'b0, 1'b0,1'b1,1'b0,16'h2222,8'd3));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b1,14'h2222,1'b0, 1'b0,1'b1,1'b1,16'h2222,8'd3));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b1,14'h3fff,1'b0, 1'b0,1'b1,1'b1,16'h7fff,8'd3));
    // back-to-back len 1 packets; dest changes during HEAD must not alter the flit
    tbl.push_back(mk(1'b1,4'd1,3'd1,1'b0,14'h0,1'b0, 1'b1,1'b0,1'b0,16'h0000,8'd4));
    tbl.push_back(mk(1'b1,4'd2,3'd1,1'b0,14'h0,1'b0, 1'b0,1'b0,1'b1,16'h8480,8'd4));
    tbl.push_back(mk(1'b1,4'd2,3'd1,1'b1,14'h0aaa,1'b0, 1'b0,1'b1,1'b1,16'h4AAA,8'd4));
    tbl.push_back(mk(1'b1,4'd2,3'd1,1'b0,14'h0,1'b0, 1'b1,1'b0,1'b0,16'h0000,8'd5));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b0,14'h0,1'b0, 1'b0,1'b0,1'b1,16'h8880,8'd5));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b1,14'h0555,1'b0, 1'b0,1'b1,1'b1,16'h4555,8'd5));
    tbl.push_back(mk(1'b0,4'd0,3'd0,1'b0,14'h0,1'b0, 1'b1,1'b0,1'b0,16'h0000,8'd6));
`endif

    // reset state
    drive(1'b0, 4'd0, 3'd0, 1'b0, 14'h0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk_w);
    #1;
    chk("rst.pkt_ready",  32'(bus_if.pkt_ready),  32'd1);
    chk("rst.word_ready", 32'(bus_if.word_ready), 32'd0);
    chk("rst.buf_load",   32'(bus_if.buf_load),   32'd0);
    chk("rst.buf_data",   32'(bus_if.buf_data),   32'd0);
    chk("rst.pkt_sent",   32'(bus_if.pkt_sent),   32'd0);
    rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i], i);

    // reset mid-packet: len 5, dest 7, after head and one payload word
    @(negedge clk_w); drive(1'b1, 4'd7, 3'd5, 1'b0, 14'h0, 1'b0);
    @(negedge clk_w); drive(1'b0, 4'd0, 3'd0, 1'b0, 14'h0, 1'b0); #1;
    chk("mid.head_load", 32'(bus_if.buf_load), 32'd1);
    chk("mid.head_data", 32'(bus_if.buf_data), 32'h9E80);
    @(negedge clk_w); drive(1'b0, 4'd0, 3'd0, 1'b1, 14'h123, 1'b0); #1;
    chk("mid.body_load", 32'(bus_if.buf_load), 32'd1);
    @(negedge clk_w); drive(1'b0, 4'd0, 3'd0, 1'b0, 14'h0, 1'b0); rst = 1'b1;
    @(negedge clk_w); rst = 1'b0; #1;
    chk("mid.pkt_ready",  32'(bus_if.pkt_ready),  32'd1);
    chk("mid.buf_load",   32'(bus_if.buf_load),   32'd0);
    chk("mid.buf_data",   32'(bus_if.buf_data),   32'd0);
    chk("mid.word_ready", 32'(bus_if.word_ready), 32'd0);
    chk("mid.pkt_sent",   32'(bus_if.pkt_sent),   32'd0);
    drive(1'b1, 4'd3, 3'd2, 1'b0, 14'h0, 1'b0);
    @(negedge clk_w); drive(1'b0, 4'd0, 3'd0, 1'b0, 14'h0, 1'b0); #1;
    chk("post.head", 32'(bus_if.buf_data), 32'h8D00);
    chk("post.head_load", 32'(bus_if.buf_load), 32'd1);
    @(negedge clk_w); drive(1'b0, 4'd0, 3'd0, 1'b1, 14'h1, 1'b0); #1;
    chk("post.w1", 32'(bus_if.buf_data), 32'h0001);
    @(negedge clk_w); drive(1'b0, 4'd0, 3'd0, 1'b1, 14'h2, 1'b0); #1;
`ifdef NOC_PKT_CHECKSUM_EN
    chk("post.w2", 32'(bus_if.buf_data), 32'h0002);
    @(negedge clk_w); drive(1'b0, 4'd0, 3'd0, 1'b0, 14'h0, 1'b0); #1;
    chk("post.crc", 32'(bus_if.buf_data), 32'h4003);
`else
    chk("post.w2", 32'(bus_if.buf_data), 32'h4002);
`endif
    @(negedge clk_w); drive(1'b0, 4'd0, 3'd0, 1'b0, 14'h0, 1'b0); #1;
    chk("post.pkt_sent", 32'(bus_if.pkt_sent), 32'd1);

    // pkt_sent wraps after 256 packets
    rst = 1'b1;
    @(negedge clk_w); rst = 1'b0;
    drive(1'b1, 4'd0, 3'd0, 1'b0, 14'h0, 1'b0);
    for (int i = 1; i <= 256; i++) begin
      int n;
      n = 0;
      while (bus_if.pkt_sent != 8'(i) && n < 8) begin
        @(negedge clk_w); #1;
        n++;
      end
      if (n >= 8) begin
        checks++;
        errors++;
        $display("FAIL wrap.timeout: pkt_sent %0d never reached %0d", bus_if.pkt_sent, i % 256);
        break;
      end
      if (i == 255) chk("wrap.255", 32'(bus_if.pkt_sent), 32'd255);
    end
    chk("wrap.0", 32'(bus_if.pkt_sent), 32'd0);
    drive(1'b0, 4'd0, 3'd0, 1'b0, 14'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
